// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB-first, one bit per clock,
// behind a start/done handshake. Results are registered and held until the next completion.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | one full-subtractor step per edge, WIDTH edges in total
// ST_DONE | single-cycle done pulse; start here begins the next operation
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] sr;
    logic             bf;
    logic [CW-1:0]    cnt;

    logic             accept, last, d_bit, bout;
    logic [WIDTH-1:0] result;

    always_comb begin
        d_bit  = sa[0] ^ sb[0] ^ bf;
        bout   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf);
        // sr holds the partial result MSB-aligned; the new bit completes it on the last step
        result = {d_bit, sr};
        last   = (cnt == CW'(WIDTH - 1));
        accept = start && ((state == ST_IDLE) || (state == ST_DONE));

        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            bf     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            bf  <= 1'b0;
            cnt <= '0;
        end else if (state == ST_RUN) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            sr <= result[WIDTH-1:1];
            bf <= bout;
            if (last) begin
                diff   <= result;
                borrow <= bout;
                zero   <= (result == '0);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
